adpll_phase_detector_n: RTL



---
 rtl/adpll_phase_detector_n.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/adpll_phase_detector_n.sv
// adpll_phase_detector_n
//   Measures the signed time between rising edges of ref_clk_i and gen_clk_i,
//   counted in fpga_clk_i cycles, for the ADPLL loop filter. It also flags
//   saturated measurements and cycle slips, and can optionally report lock.
//
// Optional feature: define PHDET_LOCK_DETECT_EN to build the lock detector.
//   Without it, locked_o is tied to 0.
//
// Ports:
//   fpga_clk_i     sampling/system clock
//   reset_n_i      asynchronous active-low reset
//   enable_i       measurement enable
//   ref_clk_i      reference clock (asynchronous)
//   gen_clk_i      DCO clock (asynchronous)
//   error_o        signed phase error, positive = gen lags ref, range +-MAX
//   error_valid_o  one-cycle strobe: error_o updated
//   overflow_o     valid with error_valid_o: magnitude clipped to MAX
//   slip_o         one-cycle pulse: leading edge repeated before its partner
//   locked_o       lock indication
module adpll_phase_detector_n #(
    parameter int ERR_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic             fpga_clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             ref_clk_i,
    input  logic             gen_clk_i,
    output logic [ERR_W-1:0] error_o,
    output logic             error_valid_o,
    output logic             overflow_o,
    output logic             slip_o,
    output logic             locked_o
);
    // The magnitude never needs the sign bit, so it lives in ERR_W-1 bits.
    // Its all-ones value is MAX, which keeps the output range symmetric.
    localparam int CW = ERR_W - 1;
    localparam logic [CW-1:0] MAX = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, REF_LEAD, GEN_LEAD} state_t;

    // ---------------- synchronisers and edge detectors ----------------
    // Both inputs see the same SYNC_STAGES+1 latency, so the relative timing
    // of the two detected edges matches that of the raw edges.
    logic [SYNC_STAGES-1:0] ref_sync, gen_sync;
    logic                   ref_dly, gen_dly;
    logic                   ref_edge, gen_edge;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ref_sync <= '0;
            gen_sync <= '0;
            ref_dly  <= 1'b0;
            gen_dly  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_clk_i};
            gen_sync <= {gen_sync[SYNC_STAGES-2:0], gen_clk_i};
            ref_dly  <= ref_sync[SYNC_STAGES-1];
            gen_dly  <= gen_sync[SYNC_STAGES-1];
        end
    end

    assign ref_edge = ref_sync[SYNC_STAGES-1] & ~ref_dly;
    assign gen_edge = gen_sync[SYNC_STAGES-1] & ~gen_dly;

    // ---------------- measurement FSM ----------------
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          done;      // measurement completes this cycle
    logic [CW-1:0] mag;
    logic          neg;
    logic          ovf;
    logic          slip_nxt;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds (cycles since the leading edge - 1), so counter+1 is the
    // edge-to-edge distance. Clipping is only possible once cnt sits at MAX.
    assign cnt_inc = (cnt == MAX) ? MAX : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        mag       = '0;
        neg       = 1'b0;
        ovf       = 1'b0;
        slip_nxt  = 1'b0;
        if (!enable_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ref_edge && gen_edge) begin
                        done = 1'b1;
                    end else if (ref_edge) begin
                        state_nxt = REF_LEAD;
                        cnt_nxt   = '0;
                    end else if (gen_edge) begin
                        state_nxt = GEN_LEAD;
                        cnt_nxt   = '0;
                    end
                end
                REF_LEAD, GEN_LEAD: begin
                    // The partner edge wins over a simultaneous repeated
                    // leading edge; the leading edge is simply dropped.
                    if ((state == REF_LEAD) ? gen_edge : ref_edge) begin
                        done      = 1'b1;
                        mag       = cnt_inc;
                        ovf       = (cnt == MAX);
                        neg       = (state == GEN_LEAD);
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if ((state == REF_LEAD) ? ref_edge : gen_edge) begin
                        slip_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ---------------- registered outputs ----------------
    logic [ERR_W-1:0] mag_ext;
    logic [ERR_W-1:0] err_nxt;

    assign mag_ext = {1'b0, mag};
    assign err_nxt = neg ? -mag_ext : mag_ext;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_o       <= '0;
            error_valid_o <= 1'b0;
            overflow_o    <= 1'b0;
            slip_o        <= 1'b0;
        end else begin
            error_valid_o <= done;
            overflow_o    <= done & ovf;
            slip_o        <= slip_nxt;
            if (done) error_o <= err_nxt;
        end
    end

    // ---------------- optional lock detector ----------------
`ifdef PHDET_LOCK_DETECT_EN
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0] LCNT = LW'(LOCK_COUNT);
    localparam logic [CW-1:0] THR  = CW'(LOCK_THRESH);

    logic [LW-1:0] lock_cnt, lock_inc;

    assign lock_inc = (lock_cnt == LCNT) ? LCNT : lock_cnt + 1'b1;

    // Updated on the same edge as error_valid_o, so locked_o changes in the
    // very cycle the qualifying (or disqualifying) sample is presented.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_cnt <= '0;
            locked_o <= 1'b0;
        end else if (done) begin
            if (ovf || (mag > THR)) begin
                lock_cnt <= '0;
                locked_o <= 1'b0;
            end else begin
                lock_cnt <= lock_inc;
                locked_o <= (lock_inc == LCNT);
            end
        end else if (slip_nxt) begin
            lock_cnt <= '0;
            locked_o <= 1'b0;
        end
    end
`else
    assign locked_o = 1'b0;
`endif

endmodule
